// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: E-stage operand forwarding, load-use detection, and a
// one-entry scoreboard that tracks a single in-flight multi-cycle operation.
module hazard_scoreboard #(
    parameter int AW     = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    RS1D,
    input  logic [AW-1:0]    RS2D,
    input  logic             UseRS1D,
    input  logic             UseRS2D,
    input  logic [AW-1:0]    RDD,
    input  logic             RegWriteD,
    input  logic             MdOpD,
    input  logic [AW-1:0]    RS1E,
    input  logic [AW-1:0]    RS2E,
    input  logic [AW-1:0]    RDE,
    input  logic             ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MdStartE,
    input  logic [AW-1:0]    RDM,
    input  logic [AW-1:0]    RDW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             MdBusy,
    output logic             MdDoneW,
    output logic [AW-1:0]    MdRdW,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam logic [3:0]       MD_INIT = 4'(MD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic          md_busy;
    logic [AW-1:0] md_rd;
    logic [3:0]    md_cnt;
    logic          lu;
    logic          sb;
    logic          hz;

    always_ff @(posedge clk) begin
        if (!rst) begin
            md_busy <= 1'b0;
            md_rd   <= '0;
            md_cnt  <= '0;
        end else if (md_busy) begin
            // A new MdStartE while busy is dropped; the entry retires after the done cycle.
            if (md_cnt != 4'd0) md_cnt <= md_cnt - 4'd1;
            else                md_busy <= 1'b0;
        end else if (MdStartE) begin
            md_busy <= 1'b1;
            md_rd   <= RDE;
            md_cnt  <= MD_INIT;
        end
    end

    assign MdBusy  = md_busy;
    assign MdDoneW = rst && md_busy && (md_cnt == 4'd0);
    assign MdRdW   = MdDoneW ? md_rd : '0;

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (rst) begin
            if (RegWriteM && (RDM == RS1E) && (RS1E != '0))      ForwardAE = 2'b10;
            else if (RegWriteW && (RDW == RS1E) && (RS1E != '0)) ForwardAE = 2'b01;
            if (RegWriteM && (RDM == RS2E) && (RS2E != '0))      ForwardBE = 2'b10;
            else if (RegWriteW && (RDW == RS2E) && (RS2E != '0)) ForwardBE = 2'b01;
        end
    end

    assign lu = ResultSrcE && (RDE != '0) &&
                ((UseRS1D && (RS1D == RDE)) || (UseRS2D && (RS2D == RDE)));

    // Structural (second md op), RAW and WAW against the outstanding destination.
    assign sb = md_busy && (MdOpD || ((md_rd != '0) &&
                ((UseRS1D && (RS1D == md_rd)) || (UseRS2D && (RS2D == md_rd)) ||
                 (RegWriteD && (RDD == md_rd)))));

    assign hz = lu || sb;

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (rst) begin
            if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else begin
                StallF = hz;
                StallD = hz;
                FlushE = hz;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallD && (StallCnt != CNT_MAX)) StallCnt <= StallCnt + CNT_ONE;
            if (FlushE && (FlushCnt != CNT_MAX)) FlushCnt <= FlushCnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// traffic compared against a cycle-indexed behavioural model.
module tb_hazard_scoreboard;

    localparam int AW     = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int NONE   = -1000;

    typedef struct packed {
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic             stall_f;
        logic             stall_d;
        logic             flush_d;
        logic             flush_e;
        logic             md_busy;
        logic             md_done;
        logic [AW-1:0]    md_rdw;
        logic [CNT_W-1:0] stall_cnt;
        logic [CNT_W-1:0] flush_cnt;
    } out_t;

    logic clk, rst;
    logic [AW-1:0] RS1D, RS2D, RDD, RS1E, RS2E, RDE, RDM, RDW;
    logic UseRS1D, UseRS2D, RegWriteD, MdOpD, ResultSrcE, PCSrcE, MdStartE;
    logic RegWriteM, RegWriteW;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, FlushD, FlushE, MdBusy, MdDoneW;
    logic [AW-1:0] MdRdW;
    logic [CNT_W-1:0] StallCnt, FlushCnt;
    out_t obs;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int m_issue = NONE;
    logic [AW-1:0] m_rd = '0;
    int m_stall = 0;
    int m_flush = 0;

    hazard_scoreboard #(.AW(AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .RS1D(RS1D), .RS2D(RS2D), .UseRS1D(UseRS1D), .UseRS2D(UseRS2D),
        .RDD(RDD), .RegWriteD(RegWriteD), .MdOpD(MdOpD),
        .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .MdStartE(MdStartE),
        .RDM(RDM), .RDW(RDW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .MdBusy(MdBusy), .MdDoneW(MdDoneW), .MdRdW(MdRdW),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    assign obs = {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
                  MdBusy, MdDoneW, MdRdW, StallCnt, FlushCnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an op issued at edge e occupies the MD_LAT cycles that follow it.
    function automatic int md_age();
        return cyc - m_issue + 1;
    endfunction

    function automatic bit mdl_busy();
        return (md_age() >= 1) && (md_age() <= MD_LAT);
    endfunction

    function automatic bit mdl_done();
        return md_age() == MD_LAT;
    endfunction

    function automatic logic [1:0] fwd(input logic [AW-1:0] rs);
        if (rs == '0) return 2'b00;
        if (RegWriteM && RDM == rs) return 2'b10;
        if (RegWriteW && RDW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic out_t exp_vec();
        out_t e;
        bit lu, sb, hz;
        e = '0;
        e.md_busy   = mdl_busy();
        e.md_done   = rst && mdl_done();
        e.md_rdw    = e.md_done ? m_rd : '0;
        e.stall_cnt = CNT_W'(m_stall);
        e.flush_cnt = CNT_W'(m_flush);
        if (rst) begin
            e.fa = fwd(RS1E);
            e.fb = fwd(RS2E);
            lu = ResultSrcE && RDE != 0 &&
                 ((UseRS1D && RS1D == RDE) || (UseRS2D && RS2D == RDE));
            sb = mdl_busy() && (MdOpD || (m_rd != 0 &&
                 ((UseRS1D && RS1D == m_rd) || (UseRS2D && RS2D == m_rd) ||
                  (RegWriteD && RDD == m_rd))));
            hz = lu || sb;
            if (PCSrcE) begin
                e.flush_d = 1'b1;
                e.flush_e = 1'b1;
            end else begin
                e.stall_f = hz;
                e.stall_d = hz;
                e.flush_e = hz;
            end
        end
        return e;
    endfunction

    task automatic tick();
        out_t e;
        bit pb;
        e  = exp_vec();
        pb = mdl_busy();
        @(posedge clk);
        cyc++;
        if (!rst) begin
            m_issue = NONE;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (MdStartE && !pb) begin
                m_issue = cyc;
                m_rd    = RDE;
            end
            if (e.stall_d && m_stall < CMAX) m_stall++;
            if (e.flush_e && m_flush < CMAX) m_flush++;
        end
        #1;
    endtask

    task automatic clear_inputs();
        {RS1D, RS2D, RDD, RS1E, RS2E, RDE, RDM, RDW} = '0;
        {UseRS1D, UseRS2D, RegWriteD, MdOpD, ResultSrcE, PCSrcE, MdStartE} = '0;
        {RegWriteM, RegWriteW} = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        RegWriteM = 1'b1; RDM = 5'd5; RS1E = 5'd5; RS2E = 5'd5;
        ResultSrcE = 1'b1; RDE = 5'd7; RS1D = 5'd7; UseRS1D = 1'b1; MdStartE = 1'b1; RDE = 5'd7;
        #1;
        n_cmp++;
        if ({ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b exp=%b", {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE}, 8'h00);
        end
        tick();
        tick();
        n_cmp++;
        if ({MdBusy, StallCnt, FlushCnt} !== '0) begin
            n_err++;
            $display("FAIL reset_state got=%h exp=0", {MdBusy, StallCnt, FlushCnt});
        end
        rst = 1'b1;
        clear_inputs();
        #1;
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_release got=%h exp=%h", obs, exp_vec());
        end
        tick();
    endtask

    task automatic test_forwarding();
        apply_reset();
        RegWriteM = 1'b1; RegWriteW = 1'b1; RDM = 5'd5; RDW = 5'd5; RS1E = 5'd5;
        #1;
        n_cmp++;
        if (ForwardAE !== 2'b10) begin
            n_err++;
            $display("FAIL fwd_m_priority got=%b exp=10", ForwardAE);
        end
        RS1E = 5'd0;
        #1;
        n_cmp++;
        if (ForwardAE !== 2'b00) begin
            n_err++;
            $display("FAIL fwd_x0 got=%b exp=00", ForwardAE);
        end
        RS1E = 5'd5; RegWriteM = 1'b0; RS2E = 5'd5;
        #1;
        n_cmp++;
        if ({ForwardAE, ForwardBE} !== 4'b0101) begin
            n_err++;
            $display("FAIL fwd_w got=%b exp=0101", {ForwardAE, ForwardBE});
        end
        tick();
        for (int i = 0; i < 40; i++) begin
            RS1E = AW'($urandom_range(0, 3)); RS2E = AW'($urandom_range(0, 3));
            RDM = AW'($urandom_range(0, 3));  RDW = AW'($urandom_range(0, 3));
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL fwd_rand cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        int s0;
        apply_reset();
        ResultSrcE = 1'b1; RDE = 5'd7; RS2D = 5'd7; UseRS2D = 1'b1;
        s0 = m_stall;
        #1;
        n_cmp++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin
            n_err++;
            $display("FAIL load_use got=%b exp=1101", {StallF, StallD, FlushD, FlushE});
        end
        tick();
        n_cmp++;
        if (StallCnt !== CNT_W'(s0 + 1)) begin
            n_err++;
            $display("FAIL load_use_cnt got=%0d exp=%0d", StallCnt, s0 + 1);
        end
        UseRS2D = 1'b0;
        #1;
        n_cmp++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) begin
            n_err++;
            $display("FAIL load_use_off got=%b exp=0000", {StallF, StallD, FlushD, FlushE});
        end
        tick();
    endtask

    task automatic test_multicycle();
        apply_reset();
        MdStartE = 1'b1; RDE = 5'd9;
        tick();
        MdStartE = 1'b0; RDE = 5'd0; RS1D = 5'd9; UseRS1D = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            #1;
            n_cmp++;
            if ({MdBusy, MdDoneW, MdRdW, StallD} !==
                {c <= 4, c == 4, (c == 4) ? 5'd9 : 5'd0, c <= 4}) begin
                n_err++;
                $display("FAIL md_timing c=%0d got=%b exp=%b", c, {MdBusy, MdDoneW, MdRdW, StallD},
                         {c <= 4, c == 4, (c == 4) ? 5'd9 : 5'd0, c <= 4});
            end
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL md_model c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_flush_overlap();
        apply_reset();
        MdStartE = 1'b1; RDE = 5'd3;
        tick();
        MdStartE = 1'b1; RDE = 5'd6; PCSrcE = 1'b1; RS1D = 5'd3; UseRS1D = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            #1;
            n_cmp++;
            if ({FlushD, FlushE, StallD, MdDoneW, MdRdW} !== {3'b110, c == 4, (c == 4) ? 5'd3 : 5'd0}) begin
                n_err++;
                $display("FAIL flush_overlap c=%0d got=%b exp=%b", c, {FlushD, FlushE, StallD, MdDoneW, MdRdW},
                         {3'b110, c == 4, (c == 4) ? 5'd3 : 5'd0});
            end
            if (c == 4) MdStartE = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        MdStartE = 1'b1; RDE = 5'd9;
        tick();
        MdStartE = 1'b0; RS1D = 5'd9; UseRS1D = 1'b1;
        tick();
        rst = 1'b0;
        MdStartE = 1'b1;
        tick();
        rst = 1'b1;
        MdStartE = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            #1;
            n_cmp++;
            if ({MdBusy, MdDoneW, StallCnt, FlushCnt} !== '0) begin
                n_err++;
                $display("FAIL reset_mid c=%0d got=%h exp=0", c, {MdBusy, MdDoneW, StallCnt, FlushCnt});
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        ResultSrcE = 1'b1; RDE = 5'd4; RS1D = 5'd4; UseRS1D = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if ({StallCnt, FlushCnt} !== {4'd15, 4'd15}) begin
            n_err++;
            $display("FAIL sat got=%0d/%0d exp=15/15", StallCnt, FlushCnt);
        end
        tick();
        n_cmp++;
        if (StallCnt !== 4'd15) begin
            n_err++;
            $display("FAIL sat_hold got=%0d exp=15", StallCnt);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) != 0);
            RS1D = AW'($urandom_range(0, 3)); RS2D = AW'($urandom_range(0, 3));
            RDD  = AW'($urandom_range(0, 3)); RS1E = AW'($urandom_range(0, 3));
            RS2E = AW'($urandom_range(0, 3)); RDE  = AW'($urandom_range(0, 3));
            RDM  = AW'($urandom_range(0, 3)); RDW  = AW'($urandom_range(0, 3));
            UseRS1D = 1'($urandom_range(0, 1)); UseRS2D = 1'($urandom_range(0, 1));
            RegWriteD = 1'($urandom_range(0, 1)); MdOpD = ($urandom_range(0, 5) == 0);
            ResultSrcE = ($urandom_range(0, 3) == 0); PCSrcE = ($urandom_range(0, 5) == 0);
            MdStartE = ($urandom_range(0, 3) == 0);
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_multicycle();
        test_flush_overlap();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL take parameters: AW, default 5, register-address width; MD_LAT, default 4, multi-cycle unit latency (legal values 2..15); CNT_W, default 16, performance-counter width.
REQ-002 SHALL have one clock; reset is synchronous and active-low. Ports are listed as name, direction, width, meaning:
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous reset, active-low (0 = reset).
REQ-005 RS1D, RS2D  in  AW  decode-stage source registers; UseRS1D, UseRS2D  in  1  source actually read.
REQ-006 RDD  in  AW, RegWriteD  in  1, MdOpD  in  1  decode-stage destination, write enable, and multi-cycle-op flag.
REQ-007 RS1E, RS2E, RDE  in  AW; ResultSrcE  in  1 (load in E); PCSrcE  in  1 (taken branch/jump); MdStartE  in  1 (multi-cycle op issues from E).
REQ-008 RDM, RDW  in  AW; RegWriteM, RegWriteW  in  1.
REQ-009 ForwardAE, ForwardBE  out  2  00 = regfile, 10 = M-stage result, 01 = W-stage result.
REQ-010 StallF, StallD, FlushD, FlushE  out  1  pipeline control.
REQ-011 MdBusy  out  1; MdDoneW  out  1 (one-cycle writeback strobe); MdRdW  out  AW (writeback register).
REQ-012 StallCnt, FlushCnt  out  CNT_W  saturating performance counters.

Function
REQ-013 ForwardAE SHALL be 10 if RegWriteM & RDM==RS1E & RS1E!=0; otherwise 01 if RegWriteW & RDW==RS1E & RS1E!=0; otherwise 00. M has priority over W. ForwardBE SHALL use the same rule with RS2E. Both are combinational.
REQ-014 Load-use hazard lu SHALL be ResultSrcE & RDE!=0 & ((UseRS1D & RS1D==RDE) | (UseRS2D & RS2D==RDE)).
REQ-015 The scoreboard SHALL hold md_busy (1 bit), md_rd (AW bits) and md_cnt (4 bits); MdBusy = md_busy.
REQ-016 On a clock edge with MdStartE=1 and md_busy=0, the block SHALL set md_busy=1, md_rd=RDE and md_cnt=MD_LAT-1.
REQ-017 MdStartE while md_busy=1 SHALL be ignored; scoreboard state is unchanged.
REQ-018 While md_busy=1 and md_cnt!=0, md_cnt SHALL decrement by 1 per cycle.
REQ-019 MdDoneW SHALL be 1, and MdRdW SHALL equal md_rd, exactly when md_busy=1 and md_cnt==0; md_busy SHALL clear at the following edge. MdRdW SHALL be 0 otherwise.
REQ-020 Net timing: MdStartE sampled at edge t gives MdBusy=1 from t+1 and MdDoneW=1 for one cycle at t+MD_LAT.
REQ-021 Scoreboard hazard sb SHALL be md_busy & (MdOpD | (md_rd!=0 & ((UseRS1D & RS1D==md_rd) | (UseRS2D & RS2D==md_rd) | (RegWriteD & RDD==md_rd)))). This covers structural, RAW and WAW hazards and includes the MdDoneW cycle.
REQ-022 Let hz = lu | sb. When PCSrcE=0: StallF = StallD = hz, FlushE = hz, FlushD = 0.
REQ-023 When PCSrcE=1: FlushD = FlushE = 1 and StallF = StallD = 0. Flush overrides stall.
REQ-024 PCSrcE SHALL NOT alter scoreboard state; an already-issued multi-cycle op completes.
REQ-025 At each edge, StallCnt SHALL increment when StallD=1 and FlushCnt when FlushE=1. Both saturate at all-ones and do not wrap.
REQ-026 All outputs except the counters and the scoreboard-derived outputs (MdBusy, MdDoneW, MdRdW) SHALL be combinational from inputs and scoreboard state.

Reset
REQ-027 At a clock edge with rst=0, the block SHALL clear md_busy, md_rd, md_cnt, StallCnt and FlushCnt to 0. This applies mid-operation; a pending multi-cycle op is discarded and no MdDoneW is produced.
REQ-028 While rst=0, the block SHALL force ForwardAE = ForwardBE = 00 and StallF = StallD = FlushD = FlushE = 0 combinationally.
REQ-029 An MdStartE sampled at the same edge as rst=0 SHALL be ignored.

Verification
REQ-030 Forwarding priority: RegWriteM = RegWriteW = 1, RDM = RDW = RS1E = 5 -> ForwardAE = 10. Then RS1E = 0 -> ForwardAE = 00.
REQ-031 Load-use stall: ResultSrcE=1, RDE=7, RS2D=7, UseRS2D=1 -> StallF = StallD = FlushE = 1 and StallCnt +1. Then UseRS2D=0 -> all 0.
REQ-032 Multi-cycle timing (MD_LAT=4): MdStartE at edge 0 with RDE=9 -> MdBusy=1 in cycles 1..4 and MdDoneW=1, MdRdW=9 in cycle 4 only. A decode read of x9 stalls in cycles 1..4 and releases in cycle 5.
REQ-033 Simultaneous events: sb active and PCSrcE=1 -> FlushD = FlushE = 1, StallD = 0, and MdDoneW still occurs on schedule.
REQ-034 Reset mid-operation: rst=0 at cycle 2 of a multi-cycle op -> MdBusy=0 next cycle, no MdDoneW, and counters = 0.
REQ-035 Counter saturation: with CNT_W=4, hold StallD=1 for 20 cycles -> StallCnt = 15 and stays at 15.
